sram_responder: RTL and testbench

Synthesizable on-chip stand-in for the board's 16-bit asynchronous SRAM. It is the responder end of the SLC-3 memory bus: the CPU drives CE/UB/LB/OE/WE/ADDR and the shared Data bus, and this block answers. After every reset it fills its storage from a program image, then serves registered reads and byte-enabled writes. The toplevel instantiates it beside the CPU, so simulation and FPGA runs need no external SRAM model.

---
 rtl/sram_responder_pkg.sv | 29 ++
 rtl/sram_responder_if.sv | 14 +
 rtl/sram_responder_init_ctrl.sv | 47 ++++
 rtl/sram_responder.sv | 89 ++++++++
 tb/tb_sram_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_responder_pkg.sv
// Shared types, boot image and helpers for the on-chip SRAM responder.
// The boot image is loaded into storage after every reset.
package sram_pkg;

  typedef enum logic {
    INIT,
    SERVE
  } sram_state_t;

  localparam int INIT_LEN = 16;

  localparam logic [15:0] INIT_IMAGE [INIT_LEN] = '{
    16'h5020, 16'h1021, 16'h5260, 16'h1262,
    16'h1401, 16'h127F, 16'h03FC, 16'h3007,
    16'hF025, 16'h2008, 16'h6442, 16'h7443,
    16'h9A7F, 16'hC1C0, 16'h0E02, 16'hF021
  };

  // Words past the end of the image boot as zero.
  function automatic logic [15:0] init_word(input logic [19:0] idx);
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < INIT_LEN; i++) begin
      if (idx == 20'(i)) w = INIT_IMAGE[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// SLC-3 memory bus control signals (active-low strobes, word address) and
// the responder's ready flag. The shared data bus is a separate inout port.
interface sram_responder_if;
  logic        ce_n;
  logic        ub_n;
  logic        lb_n;
  logic        oe_n;
  logic        we_n;
  logic [19:0] addr;
  logic        ready;

  modport master (output ce_n, ub_n, lb_n, oe_n, we_n, addr, input ready);
  modport slave  (input ce_n, ub_n, lb_n, oe_n, we_n, addr, output ready);
endinterface

// File: rtl/sram_responder_init_ctrl.sv
// Boot sequencer: walks every storage word once, supplying image data,
// then parks in SERVE with ready held high until the next reset.
module sram_init_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic [15:0]       init_data_o,
  output logic              ready_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  sram_state_t       state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= SERVE;
            ready_q <= 1'b1;
          end
        end
        SERVE:   ready_q <= 1'b1;
        default: state_q <= INIT;
      endcase
    end
  end

  assign init_we_o   = (state_q == INIT);
  assign init_addr_o = cnt_q;
  assign init_data_o = init_word(20'(cnt_q));
  assign ready_o     = ready_q;

endmodule

// File: rtl/sram_responder.sv
// On-chip stand-in for the 16-bit asynchronous SRAM: boots from the image,
// then serves registered reads and byte-enabled writes on the SLC-3 bus.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  sram_responder_if.slave     bus,
  inout  wire  [15:0]         data_io
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [15:0]       init_data;
  logic              ready;

  sram_init_ctrl #(.ADDR_W(ADDR_W)) u_init_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_data_o (init_data),
    .ready_o     (ready)
  );

  assign bus.ready = ready;

  logic in_range;
  logic bus_wr;
  logic bus_rd;

  // Upper address bits beyond the implemented depth must be zero.
  assign in_range = ((bus.addr >> ADDR_W) == 20'd0);
  assign bus_wr   = ready && rst_ni && !bus.ce_n && !bus.we_n;
  assign bus_rd   = ready && !bus.ce_n && !bus.oe_n && bus.we_n;

  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [1:0]        wr_be;

  always_comb begin
    wr_addr = init_addr;
    wr_data = init_data;
    wr_be   = {2{init_we}};
    if (!init_we) begin
      wr_addr = bus.addr[ADDR_W-1:0];
      wr_data = data_io;
      wr_be   = (bus_wr && in_range) ? ~{bus.ub_n, bus.lb_n} : 2'b00;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 2; b++) begin
      if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  logic [15:0] rdata_q, rdata_d;
  logic        drive_q, drive_d;

  always_comb begin
    rdata_d = rdata_q;
    drive_d = 1'b0;
    if (bus_rd) begin
      drive_d = 1'b1;
      rdata_d = in_range ? mem[bus.addr[ADDR_W-1:0]] : 16'h0000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= 16'h0000;
      drive_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      drive_q <= drive_d;
    end
  end

  // Bus driven only from registers; WE low always leaves it released.
  assign data_io = drive_q ? rdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: boot timing, table-driven bus vectors,
// and hand sequences for WE priority and reset during serve/init.
module tb_sram_responder;

  localparam logic [15:0] FLOAT = 16'hFFFF;  // released bus, seen through the pull-up
  localparam logic [15:0] IMG0  = 16'h5020;
  localparam logic [15:0] IMG5  = 16'h127F;
  localparam logic [15:0] IMG7  = 16'h3007;
  localparam logic [15:0] IMG15 = 16'hF021;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tb_drv;
  logic [15:0] tb_data;
  wire  [15:0] data_bus;

  assign data_bus = tb_drv ? tb_data : 16'hzzzz;
  pullup (data_bus);

  sram_responder_if bus_if ();

  sram_responder #(.ADDR_W(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus_if.slave),
    .data_io (data_bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ce_n, ub_n, lb_n, oe_n, we_n;
    logic [19:0] addr;
    logic        drv;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ce, ub, lb, oe, we, input logic [19:0] a,
                              input logic drv, input logic [15:0] wd, input logic [15:0] exp);
    vec_t v;
    v.ce_n = ce; v.ub_n = ub; v.lb_n = lb; v.oe_n = oe; v.we_n = we;
    v.addr = a; v.drv = drv; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t rd(input logic [19:0] a, input logic [15:0] exp);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, 1'b0, 16'h0000, exp);
  endfunction

  function automatic vec_t wr(input logic [19:0] a, input logic ub, lb, input logic [15:0] wd);
    return mk(1'b0, ub, lb, 1'b1, 1'b0, a, 1'b1, wd, wd);
  endfunction

  function automatic vec_t idle();
    return mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'h0, 1'b0, 16'h0000, FLOAT);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus_if.ce_n = v.ce_n;
    bus_if.ub_n = v.ub_n;
    bus_if.lb_n = v.lb_n;
    bus_if.oe_n = v.oe_n;
    bus_if.we_n = v.we_n;
    bus_if.addr = v.addr;
    tb_drv      = v.drv;
    tb_data     = v.wd;
  endtask

  // Counts edges from release until ready, checking the bus stays released.
  task automatic wait_ready(input string name);
    int rise;
    int bad_float;
    rise = 0;
    bad_float = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (bus_if.ready === 1'b1) begin
        rise = i;
        break;
      end
      if (data_bus !== FLOAT) bad_float++;
    end
    $display("%s: ready after %0d cycles", name, rise);
    check({name, "_ready_cycle"}, 32'(rise), 32'd256);
    check({name, "_init_float"}, 32'(bad_float), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    apply(idle());

    // Reset held low for two cycles.
    step();
    step();
    check("rst_ready", 32'(bus_if.ready), 32'd0);
    check("rst_data", 32'(data_bus), 32'(FLOAT));

    rst_n = 1'b1;
    wait_ready("boot");

    vecs.push_back(rd(20'd0, IMG0));
    vecs.push_back(rd(20'd16, 16'h0000));
    vecs.push_back(rd(20'd15, IMG15));
    vecs.push_back(rd(20'd255, 16'h0000));
    vecs.push_back(idle());
    vecs.push_back(wr(20'd5, 1'b0, 1'b0, 16'h1234));
    vecs.push_back(rd(20'd5, 16'h1234));
    vecs.push_back(idle());
    vecs.push_back(wr(20'd5, 1'b1, 1'b0, 16'hABCD));
    vecs.push_back(rd(20'd5, 16'h12CD));
    vecs.push_back(idle());
    vecs.push_back(wr(20'd5, 1'b0, 1'b1, 16'h5678));
    vecs.push_back(rd(20'd5, 16'h56CD));
    vecs.push_back(idle());
    vecs.push_back(wr(20'd5, 1'b1, 1'b1, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 20'd5, 1'b0, 16'h0000, 16'h56CD));
    vecs.push_back(idle());
    vecs.push_back(wr(20'd255, 1'b0, 1'b0, 16'hA5A5));
    vecs.push_back(rd(20'd255, 16'hA5A5));
    vecs.push_back(idle());
    vecs.push_back(wr(20'h00100, 1'b0, 1'b0, 16'hBEEF));
    vecs.push_back(rd(20'h00100, 16'h0000));
    vecs.push_back(rd(20'd0, IMG0));
    vecs.push_back(idle());
    vecs.push_back(wr(20'h00105, 1'b0, 1'b0, 16'h9999));
    vecs.push_back(rd(20'd5, 16'h56CD));
    vecs.push_back(rd(20'h80000, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'd0, 1'b0, 16'h0000, FLOAT));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'd0, 1'b0, 16'h0000, FLOAT));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      step();
      $display("vec%0d ce=%b ub=%b lb=%b oe=%b we=%b addr=%h data=%h", i,
               vecs[i].ce_n, vecs[i].ub_n, vecs[i].lb_n, vecs[i].oe_n, vecs[i].we_n,
               vecs[i].addr, data_bus);
      check($sformatf("vec%0d", i), 32'(data_bus), 32'(vecs[i].exp));
    end

    // WE low with OE low: written, never driven; read appears after WE rises.
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd7, 1'b1, 16'h5555, 16'h5555));
    step();
    step();
    bus_if.we_n = 1'b1;
    tb_drv = 1'b0;
    #1;
    $display("we_prio: released bus=%h", data_bus);
    check("we_prio_release", 32'(data_bus), 32'(FLOAT));
    step();
    $display("we_prio: read addr=7 data=%h", data_bus);
    check("we_prio_read", 32'(data_bus), 32'h5555);

    // Reset while serving a read, then reset again partway through boot.
    apply(idle());
    step();
    apply(wr(20'd5, 1'b0, 1'b0, 16'h1234));
    step();
    apply(rd(20'd5, 16'h1234));
    step();
    check("pre_reset_read", 32'(data_bus), 32'h1234);
    rst_n = 1'b0;
    step();
    $display("serve reset: ready=%b data=%h", bus_if.ready, data_bus);
    check("serve_rst_ready", 32'(bus_if.ready), 32'd0);
    check("serve_rst_data", 32'(data_bus), 32'(FLOAT));
    apply(idle());
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_ready("reboot");

    apply(rd(20'd5, IMG5));
    step();
    $display("reboot read addr=5 data=%h", data_bus);
    check("reboot_addr5", 32'(data_bus), 32'(IMG5));
    apply(rd(20'd7, IMG7));
    step();
    $display("reboot read addr=7 data=%h", data_bus);
    check("reboot_addr7", 32'(data_bus), 32'(IMG7));
    apply(idle());
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
